wb_commit: RTL and testbench



---
 rtl/wb_commit_pkg.sv | 30 +++
 rtl/wb_fifo.sv | 59 +++++
 rtl/wb_commit.sv | 109 ++++++++++
 tb/tb_wb_commit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_pkg.sv
// Shared register-file widths and the long-latency completion entry used by
// the writeback commit block and its completion FIFO.
package wb_commit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;
  localparam int REG_NUM    = 32;

  localparam logic            WRITE_ENABLE  = 1'b1;
  localparam logic            WRITE_DISABLE = 1'b0;
  localparam logic [REG_W-1:0] ZERO_WORD    = '0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_word_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_word_t data;
  } ll_entry_t;

  localparam int LL_ENTRY_W = $bits(ll_entry_t);

  function automatic logic [REG_NUM-1:0] reg_onehot(input reg_addr_t a);
    logic [REG_NUM-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for long-latency completions; head is visible
// combinationally, push is refused when full and pop is ignored when empty.
module wb_fifo
  import wb_commit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = LL_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count guarantees stale
  // words are never presented as valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/wb_commit.sv
// Register-file write port arbiter: in-order pipeline writeback has priority,
// buffered long-latency completions drain in the gaps; tracks pending writes.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int QDEPTH       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        ll_issue,
  input  logic [4:0]  ll_issue_addr,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_waddr,
  input  logic [31:0] ll_wdata,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] busy,
  output logic        stall_req
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] STARVE_SAT  = CNT_W'(STARVE_LIMIT);

  logic             w_full;
  logic             w_empty;
  ll_entry_t        w_head;
  ll_entry_t        w_push_entry;
  logic             w_push;
  logic             w_pop;
  logic             w_pipe_wr;
  logic             w_head_blocked;
  logic [REG_NUM-1:0] w_set_mask;
  logic [REG_NUM-1:0] w_clr_mask;

  logic [REG_NUM-1:0] r_busy;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic               r_stall_req;

  // A pipe write to r0 is treated as no write so the FIFO head may use the slot.
  assign w_pipe_wr      = pipe_we && (pipe_waddr != '0);
  assign w_pop          = !w_pipe_wr && !w_empty;
  assign w_head_blocked = !w_empty && !w_pop;
  assign ll_ready       = !w_full;
  assign w_push         = ll_valid && !w_full;
  assign w_push_entry   = '{addr: ll_waddr, data: ll_wdata};

  wb_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (LL_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // NOTE: every output of this always_comb gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    we    = WRITE_DISABLE;
    waddr = '0;
    wdata = ZERO_WORD;
    if (w_pipe_wr) begin
      we    = WRITE_ENABLE;
      waddr = pipe_waddr;
      wdata = pipe_wdata;
    end else if (!w_empty) begin
      we    = (w_head.addr != '0);
      waddr = w_head.addr;
      wdata = w_head.data;
    end
  end

  assign w_set_mask = (ll_issue && (ll_issue_addr != '0)) ? reg_onehot(ll_issue_addr) : '0;
  assign w_clr_mask = w_pop ? reg_onehot(w_head.addr) : '0;

  // Clear before set: re-issuing a register on the cycle its old result
  // retires must leave it pending.
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_stall_req  <= 1'b0;
    end else begin
      r_stall_req <= (r_starve_cnt == STARVE_LAST) && w_head_blocked;
      if (!w_head_blocked)                r_starve_cnt <= '0;
      else if (r_starve_cnt != STARVE_SAT) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  assign busy      = r_busy;
  assign stall_req = r_stall_req;

endmodule

// File: tb/tb_wb_commit.sv
// Directed and randomized check of wb_commit against a queue-based model of
// the write-port, scoreboard and starvation rules.
module tb_wb_commit;
  import wb_commit_pkg::*;

  localparam int QDEPTH       = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        ll_issue;
  logic [4:0]  ll_issue_addr;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_waddr;
  logic [31:0] ll_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy;
  logic        stall_req;

  wb_commit #(.QDEPTH(QDEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_we       (pipe_we),
    .pipe_waddr    (pipe_waddr),
    .pipe_wdata    (pipe_wdata),
    .ll_issue      (ll_issue),
    .ll_issue_addr (ll_issue_addr),
    .ll_valid      (ll_valid),
    .ll_ready      (ll_ready),
    .ll_waddr      (ll_waddr),
    .ll_wdata      (ll_wdata),
    .we            (we),
    .waddr         (waddr),
    .wdata         (wdata),
    .busy          (busy),
    .stall_req     (stall_req)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: queue of pending completions, pending bitmap, blocked streak.
  ll_entry_t   m_q[$];
  logic [31:0] m_busy;
  int          m_streak;
  logic        m_stall;
  int          inflight[$];
  int          stall_pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst           = 1'b0;
    pipe_we       = 1'b0;
    pipe_waddr    = '0;
    pipe_wdata    = '0;
    ll_issue      = 1'b0;
    ll_issue_addr = '0;
    ll_valid      = 1'b0;
    ll_waddr      = '0;
    ll_wdata      = '0;
  endtask

  task automatic model_reset();
    m_q.delete();
    inflight.delete();
    m_busy   = '0;
    m_streak = 0;
    m_stall  = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied; checks, then advances one clock.
  task automatic cycle();
    logic        pipe_wr, exp_we, exp_ready, pop, push, nxt_stall;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data, nxt_busy;
    int          nxt_streak;
    #1;
    pipe_wr   = pipe_we && (pipe_waddr != 0);
    exp_ready = (m_q.size() < QDEPTH);
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    if (pipe_wr) begin
      exp_we = 1'b1; exp_addr = pipe_waddr; exp_data = pipe_wdata;
    end else if (m_q.size() > 0) begin
      exp_we = (m_q[0].addr != 0); exp_addr = m_q[0].addr; exp_data = m_q[0].data;
    end
    chk("we", 32'(we), 32'(exp_we));
    chk("waddr", 32'(waddr), 32'(exp_addr));
    chk("wdata", wdata, exp_data);
    chk("ll_ready", 32'(ll_ready), 32'(exp_ready));
    chk("busy", busy, m_busy);
    chk("stall_req", 32'(stall_req), 32'(m_stall));
    if (stall_req) stall_pulses++;

    pop        = !pipe_wr && (m_q.size() > 0);
    push       = ll_valid && exp_ready;
    nxt_stall  = (m_streak == STARVE_LIMIT - 1) && (m_q.size() > 0) && !pop;
    nxt_streak = ((m_q.size() == 0) || pop) ? 0 : m_streak + 1;
    nxt_busy   = m_busy;
    if (pop) nxt_busy[m_q[0].addr] = 1'b0;
    if (ll_issue && ll_issue_addr != 0) nxt_busy[ll_issue_addr] = 1'b1;

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back('{addr: ll_waddr, data: ll_wdata});
        for (int k = 0; k < inflight.size(); k++)
          if (inflight[k] == int'(ll_waddr)) begin
            inflight.delete(k);
            break;
          end
      end
      if (ll_issue && ll_issue_addr != 0) inflight.push_back(int'(ll_issue_addr));
      m_busy   = nxt_busy;
      m_streak = nxt_streak;
      m_stall  = nxt_stall;
    end
    @(negedge clk);
  endtask

  initial begin
    int cq[$];
    stall_pulses = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Reset state, idle
    #1;
    chk("rst_we", 32'(we), 0);
    chk("rst_busy", busy, 0);
    chk("rst_ll_ready", 32'(ll_ready), 1);
    chk("rst_stall", 32'(stall_req), 0);
    cycle();

    // Single long-latency op to r5
    ll_issue = 1'b1; ll_issue_addr = 5'd5;
    cycle(); idle();
    #1 chk("r5_busy_t1", 32'(busy[5]), 1);
    cycle(); cycle();
    ll_valid = 1'b1; ll_waddr = 5'd5; ll_wdata = 32'hDEADBEEF;
    cycle(); idle();
    #1;
    chk("r5_we_t4", 32'(we), 1);
    chk("r5_waddr_t4", 32'(waddr), 5);
    chk("r5_wdata_t4", wdata, 32'hDEADBEEF);
    cycle();
    #1 chk("r5_busy_t5", 32'(busy[5]), 0);
    cycle();

    // Pipe priority over a same-cycle completion
    ll_issue = 1'b1; ll_issue_addr = 5'd7;
    cycle(); idle();
    ll_valid = 1'b1; ll_waddr = 5'd7; ll_wdata = 32'h77;
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h11;
    #1 chk("prio_r3_first", 32'(waddr), 3);
    cycle(); idle();
    pipe_we = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h22;
    #1 chk("prio_pipe_again", 32'(waddr), 4);
    cycle(); idle();
    #1;
    chk("prio_r7_addr", 32'(waddr), 7);
    chk("prio_r7_data", wdata, 32'h77);
    cycle();

    // Starvation: pipe busy every cycle, three completions into a 2-deep FIFO
    foreach (cq[i]) cq.delete(i);
    cq.push_back(8); cq.push_back(10); cq.push_back(11);
    for (int i = 0; i < 3; i++) begin
      idle(); ll_issue = 1'b1; ll_issue_addr = 5'(cq[i]);
      cycle();
    end
    stall_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      logic accepted;
      idle();
      pipe_we = !m_stall; pipe_waddr = 5'(20 + i); pipe_wdata = 32'(i) + 32'h100;
      accepted = 1'b0;
      if (cq.size() > 0) begin
        ll_valid = 1'b1; ll_waddr = 5'(cq[0]); ll_wdata = 32'hC000 + 32'(cq[0]);
        accepted = (m_q.size() < QDEPTH);
      end
      #1;
      if (i == 2) chk("starve_full_ready", 32'(ll_ready), 0);
      if (i == 5) chk("starve_stall_pulse", 32'(stall_req), 1);
      if (i == 6) chk("starve_ready_back", 32'(ll_ready), 1);
      cycle();
      if (accepted) void'(cq.pop_front());
    end
    chk("starve_pulse_count", 32'(stall_pulses), 1);
    idle();
    repeat (4) cycle();

    // r0 completion and r0 pipe write
    ll_valid = 1'b1; ll_waddr = 5'd0; ll_wdata = 32'hBAD;
    pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h55;
    #1 chk("r0_we_push", 32'(we), 0);
    cycle(); idle();
    pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h56;
    #1;
    chk("r0_we_pop", 32'(we), 0);
    chk("r0_busy", busy, 0);
    cycle(); idle();
    #1 chk("r0_drained_ready", 32'(ll_ready), 1);
    cycle();

    // Issue r9 on the cycle its previous result retires, then reset mid-queue
    ll_issue = 1'b1; ll_issue_addr = 5'd9;
    cycle(); idle();
    ll_valid = 1'b1; ll_waddr = 5'd9; ll_wdata = 32'h99;
    cycle(); idle();
    ll_issue = 1'b1; ll_issue_addr = 5'd9;
    #1 chk("r9_pop_addr", 32'(waddr), 9);
    cycle(); idle();
    #1 chk("r9_busy_kept", 32'(busy[9]), 1);
    ll_valid = 1'b1; ll_waddr = 5'd9; ll_wdata = 32'h999;
    pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h1;
    cycle(); idle();
    rst = 1'b1;
    cycle(); idle();
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_we", 32'(we), 0);
    chk("rst_mid_ready", 32'(ll_ready), 1);
    cycle();

    // Randomized traffic honouring the decode and MEM/WB contracts
    for (int n = 0; n < 400; n++) begin
      int r;
      idle();
      rst = ($urandom_range(0, 199) == 0);
      pipe_we = !m_stall && ($urandom_range(0, 99) < 60);
      r = $urandom_range(0, 31);
      pipe_waddr = m_busy[r] ? 5'd0 : 5'(r);
      pipe_wdata = $urandom;
      if ($urandom_range(0, 99) < 30) begin
        r = $urandom_range(1, 31);
        if (!m_busy[r]) begin
          ll_issue = 1'b1; ll_issue_addr = 5'(r);
        end
      end
      if (inflight.size() > 0 && $urandom_range(0, 99) < 50) begin
        r = $urandom_range(0, inflight.size() - 1);
        ll_valid = 1'b1; ll_waddr = 5'(inflight[r]); ll_wdata = $urandom;
      end else if ($urandom_range(0, 99) < 5) begin
        ll_valid = 1'b1; ll_waddr = 5'd0; ll_wdata = $urandom;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
